// File: rtl/fifo_beat_packer.sv
// fifo_beat_packer: pops narrow entries from an upstream FIFO and packs
// N_PACK of them into one wide beat for a ready/valid sink. Partial beats
// leave with a lane mask on flush or after FLUSH_TIMEOUT idle cycles.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   in_first       head entry of the upstream FIFO
//   in_notEmpty    upstream head entry is valid
//   in_deq_en      pop strobe to the upstream FIFO (combinational)
//   flush          level; emit any partial beat while high
//   out_data       packed beat, lane i at [i*N_IN_BITS +: N_IN_BITS]
//   out_mask       lane-valid mask
//   out_valid      beat presented
//   out_ready      sink accepts the beat
//   busy           entries are buffered or a beat is presented
module fifo_beat_packer #(
  parameter int unsigned N_IN_BITS     = 32,
  parameter int unsigned N_PACK        = 4,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_IN_BITS-1:0]          in_first,
  input  logic                          in_notEmpty,
  output logic                          in_deq_en,
  input  logic                          flush,
  output logic [N_IN_BITS*N_PACK-1:0]   out_data,
  output logic [N_PACK-1:0]             out_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int unsigned CNT_W  = $clog2(N_PACK + 1);
  localparam int unsigned IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam int unsigned BEAT_W = N_IN_BITS * N_PACK;
  localparam int unsigned MASK_W = N_PACK + 1;

  logic [N_IN_BITS-1:0] r_acc [N_PACK];
  logic [CNT_W-1:0]     r_cnt;
  logic [IDLE_W-1:0]    r_idle;
  logic [BEAT_W-1:0]    r_data;
  logic [N_PACK-1:0]    r_mask;
  logic                 r_valid;

  logic                 w_slot_free;
  logic                 w_full;
  logic                 w_timeout;
  logic                 w_partial;
  logic                 w_xfer;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_lane;
  logic [MASK_W-1:0]    w_mask_ext;
  logic [N_PACK-1:0]    w_mask;
  logic [BEAT_W-1:0]    w_beat;

  // Transfer decision: a full accumulator always goes; a partial one needs flush or timeout.
  assign w_slot_free = !r_valid || out_ready;
  assign w_full      = (r_cnt == CNT_W'(N_PACK)) && w_slot_free;
  assign w_timeout   = (FLUSH_TIMEOUT != 0) && (r_idle == IDLE_W'(FLUSH_TIMEOUT));
  assign w_partial   = (r_cnt != '0) && (r_cnt < CNT_W'(N_PACK)) && w_slot_free &&
                       (flush || w_timeout);
  assign w_xfer      = w_full || w_partial;

  // Pop whenever there is room, counting the lane freed by a same-cycle transfer.
  assign w_pop     = in_notEmpty && !reset && ((r_cnt < CNT_W'(N_PACK)) || w_xfer);
  assign in_deq_en = w_pop;
  assign w_lane    = w_xfer ? '0 : r_cnt;

  // Mask of the filled lanes; for a full accumulator this is all ones.
  assign w_mask_ext = MASK_W'(1) << r_cnt;
  assign w_mask     = N_PACK'(w_mask_ext - MASK_W'(1));

  // Beat image with unfilled lanes forced to zero.
  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < N_PACK; i++) begin
      if (CNT_W'(i) < r_cnt) w_beat[i*N_IN_BITS +: N_IN_BITS] = r_acc[i];
    end
  end

  // Accumulator lanes and fill count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_PACK; i++) r_acc[i] <= '0;
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PACK; i++) begin
        if (w_pop && (w_lane == CNT_W'(i))) r_acc[i] <= in_first;
      end
      if (w_xfer)     r_cnt <= w_pop ? CNT_W'(1) : '0;
      else if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Idle counter: only runs while a partial beat is waiting with no pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_pop || w_xfer || (r_cnt == '0)) begin
      r_idle <= '0;
    end else if ((FLUSH_TIMEOUT != 0) && (r_idle != IDLE_W'(FLUSH_TIMEOUT))) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Output register; data and mask only change on a transfer, so they hold under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_beat;
      r_mask  <= w_mask;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_mask  = r_mask;
  assign out_valid = r_valid;
  assign busy      = (r_cnt != '0) || r_valid;

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset)
    in_deq_en |-> in_notEmpty)
    else $fatal(1, "in_deq_en asserted with in_notEmpty low");

  a_hold_under_stall: assert property (@(posedge clk) disable iff (reset)
    (r_valid && !out_ready) |=> ($stable(r_data) && $stable(r_mask)))
    else $fatal(1, "out_data/out_mask changed while stalled");

endmodule

// File: tb/tb_fifo_beat_packer.sv
// Bench for fifo_beat_packer: a queue-based model of the packer checked every
// cycle, directed scenarios with literal expectations, a random phase, and a
// second instance with the idle timeout disabled.
module tb_fifo_beat_packer;

  localparam int NB = 32;
  localparam int NP = 4;
  localparam int TO = 16;
  localparam int BW = NB * NP;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] in_first;
  logic          in_notEmpty;
  logic          in_deq_en;
  logic          flush;
  logic [BW-1:0] out_data;
  logic [NP-1:0] out_mask;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  logic [NB-1:0] first0;
  logic          ne0, deq0, flush0, valid0, ready0, busy0;
  logic [BW-1:0] data0;
  logic [NP-1:0] mask0;

  always #5 clk = ~clk;

  fifo_beat_packer #(.N_IN_BITS(NB), .N_PACK(NP), .FLUSH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_first(in_first), .in_notEmpty(in_notEmpty),
    .in_deq_en(in_deq_en), .flush(flush), .out_data(out_data), .out_mask(out_mask),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  fifo_beat_packer #(.N_IN_BITS(NB), .N_PACK(NP), .FLUSH_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .in_first(first0), .in_notEmpty(ne0),
    .in_deq_en(deq0), .flush(flush0), .out_data(data0), .out_mask(mask0),
    .out_valid(valid0), .out_ready(ready0), .busy(busy0));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Stimulus knobs and upstream FIFO contents
  logic          s_flush, s_ready, s_avail;
  logic [NB-1:0] src_q[$];

  // Model state: buffered entries, presented beat, idle count
  logic [NB-1:0] m_acc[$];
  logic          m_valid;
  logic [BW-1:0] m_data;
  logic [NP-1:0] m_mask;
  int            m_idle;

  typedef struct {
    logic [BW-1:0] d;
    logic [NP-1:0] m;
    int            c;
  } beat_t;
  beat_t got[$];
  int    pops[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_mask  = '0;
    m_idle  = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle();
    bit sf, full, part, xfer, pop;
    int sz;
    beat_t b;
    @(negedge clk);
    flush       = s_flush;
    out_ready   = s_ready;
    in_notEmpty = s_avail && (src_q.size() > 0);
    in_first    = in_notEmpty ? src_q[0] : NB'($urandom);
    #1;
    sz   = m_acc.size();
    sf   = !m_valid || out_ready;
    full = (sz == NP) && sf;
    part = (sz > 0) && (sz < NP) && sf && (flush || (TO != 0 && m_idle == TO));
    xfer = full || part;
    pop  = in_notEmpty && ((sz < NP) || xfer);
    chk("deq_en", BW'(in_deq_en), BW'(pop));
    chk("out_valid", BW'(out_valid), BW'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_mask", BW'(out_mask), BW'(m_mask));
    chk("busy", BW'(busy), BW'((sz > 0) || m_valid));
    if (out_valid && out_ready) begin
      b.d = out_data; b.m = out_mask; b.c = cyc;
      got.push_back(b);
    end
    if (in_deq_en) pops.push_back(cyc);
    @(posedge clk);
    if (xfer) begin
      m_data = '0;
      for (int i = 0; i < sz; i++) m_data[i*NB +: NB] = m_acc[i];
      m_mask  = NP'((1 << sz) - 1);
      m_valid = 1'b1;
      m_acc.delete();
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (pop || xfer || sz == 0) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    if (pop) m_acc.push_back(src_q.pop_front());
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    got.delete();
    pops.delete();
  endtask

  initial begin
    int off_cnt;
    int bad;
    reset = 1'b1;
    s_flush = 1'b0; s_ready = 1'b1; s_avail = 1'b1;
    flush = 1'b0; out_ready = 1'b1; in_notEmpty = 1'b0; in_first = '0;
    first0 = '0; ne0 = 1'b0; flush0 = 1'b0; ready0 = 1'b1;
    model_reset();
    #1;
    chk("reset_valid", BW'(out_valid), '0);
    chk("reset_busy", BW'(busy), '0);
    chk("reset_deq", BW'(in_deq_en), '0);
    chk("reset_mask", BW'(out_mask), '0);
    chk("reset_data", out_data, '0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // Streaming 1..8 with an always-ready sink
    clear_logs();
    for (int i = 1; i <= 8; i++) src_q.push_back(NB'(i));
    run(12);
    chk("stream_pops", BW'(pops.size()), BW'(8));
    if (pops.size() == 8) chk("stream_pop_run", BW'(pops[7] - pops[0]), BW'(7));
    chk("stream_beats", BW'(got.size()), BW'(2));
    if (got.size() == 2) begin
      chk("stream_beat0", got[0].d, 128'h00000004_00000003_00000002_00000001);
      chk("stream_mask0", BW'(got[0].m), BW'(4'hF));
      chk("stream_beat1", got[1].d, 128'h00000008_00000007_00000006_00000005);
      chk("stream_mask1", BW'(got[1].m), BW'(4'hF));
      chk("stream_latency", BW'(got[0].c - pops[3]), BW'(2));
      chk("stream_b2b", BW'(got[1].c - got[0].c), BW'(4));
    end

    // Backpressure: sink stalled for 10 cycles with a continuous source
    clear_logs();
    s_ready = 1'b0;
    for (int i = 1; i <= 12; i++) src_q.push_back(NB'(32'h100 + i));
    run(10);
    chk("bp_pops", BW'(pops.size()), BW'(8));
    chk("bp_held_beat", out_data, 128'h00000104_00000103_00000102_00000101);
    chk("bp_deq_low", BW'(in_deq_en), '0);
    s_ready = 1'b1;
    run(10);
    chk("bp_beats", BW'(got.size()), BW'(3));
    if (got.size() == 3) begin
      chk("bp_drain_b2b", BW'(got[1].c - got[0].c), BW'(1));
      chk("bp_beat1", got[1].d, 128'h00000108_00000107_00000106_00000105);
      chk("bp_beat2", got[2].d, 128'h0000010C_0000010B_0000010A_00000109);
    end

    // Idle timeout on a two-entry partial beat
    run(3);
    clear_logs();
    src_q.push_back(NB'(32'hA));
    src_q.push_back(NB'(32'hB));
    run(25);
    chk("to_beats", BW'(got.size()), BW'(1));
    if (got.size() == 1 && pops.size() == 2) begin
      chk("to_delay", BW'(got[0].c - pops[1]), BW'(18));
      chk("to_data", got[0].d, 128'h0000000B_0000000A);
      chk("to_mask", BW'(got[0].m), BW'(4'h3));
    end

    // Flush racing a pop with three lanes filled
    clear_logs();
    for (int i = 1; i <= 3; i++) src_q.push_back(NB'(i));
    run(3);
    src_q.push_back(NB'(32'hC));
    s_flush = 1'b1;
    run(2);
    s_flush = 1'b0;
    run(3);
    chk("fl_beats", BW'(got.size()), BW'(2));
    if (got.size() == 2) begin
      chk("fl_beat0", got[0].d, 128'h00000003_00000002_00000001);
      chk("fl_mask0", BW'(got[0].m), BW'(4'h7));
      chk("fl_beat1", got[1].d, 128'h0000000C);
      chk("fl_mask1", BW'(got[1].m), BW'(4'h1));
    end

    // Asynchronous reset with two lanes filled and a stalled beat
    clear_logs();
    s_ready = 1'b0;
    for (int i = 1; i <= 6; i++) src_q.push_back(NB'(32'h10 + i));
    run(6);
    chk("rst_pre_valid", BW'(out_valid), BW'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", BW'(out_valid), '0);
    chk("rst_busy", BW'(busy), '0);
    chk("rst_deq", BW'(in_deq_en), '0);
    chk("rst_mask", BW'(out_mask), '0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    s_ready = 1'b1;
    for (int i = 1; i <= 4; i++) src_q.push_back(NB'(32'h20 + i));
    run(8);
    chk("rst_beats", BW'(got.size()), BW'(1));
    if (got.size() == 1) chk("rst_beat", got[0].d, 128'h00000024_00000023_00000022_00000021);

    // Random traffic: source gaps, sink stalls, occasional flush
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (off_cnt > 0) begin
        s_avail = 1'b0;
        off_cnt--;
      end else begin
        s_avail = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < 3) off_cnt = $urandom_range(5, 30);
      end
      s_ready = ($urandom_range(0, 9) < 7);
      s_flush = ($urandom_range(0, 19) == 0);
      if (src_q.size() < 4) src_q.push_back(NB'($urandom));
      cycle();
    end
    s_avail = 1'b1; s_ready = 1'b1; s_flush = 1'b1;
    run(20);
    s_flush = 1'b0;
    run(2);

    // Timeout disabled: a partial beat waits until flushed
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ne0 = 1'b1;
      first0 = (k == 0) ? NB'(32'h55) : NB'(32'h66);
      #1 chk("to0_deq", BW'(deq0), BW'(1));
    end
    @(negedge clk);
    ne0 = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1 if (valid0) bad++;
    end
    chk("to0_no_beat", BW'(bad), '0);
    chk("to0_busy", BW'(busy0), BW'(1));
    @(negedge clk);
    flush0 = 1'b1;
    @(negedge clk);
    flush0 = 1'b0;
    #1;
    chk("to0_valid", BW'(valid0), BW'(1));
    chk("to0_mask", BW'(mask0), BW'(4'h3));
    chk("to0_data", data0, 128'h00000066_00000055);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_beat_packer.md
# fifo_beat_packer

Downstream consumer of the BRAM-backed FIFO: pops narrow entries through the FIFO's first/deq_en/notEmpty interface and packs N_PACK consecutive entries into one wide beat for a ready/valid sink. Partial beats are emitted with a lane mask on an explicit flush or after an idle timeout. Sustains one pop per cycle when the sink is ready.

## Interface
- N_IN_BITS, 32, width of one FIFO entry
- N_PACK, 4, entries per output beat (≥2)
- FLUSH_TIMEOUT, 16, idle cycles before a partial beat is forced out; 0 disables the timeout

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_first  in  N_IN_BITS  head entry of the upstream FIFO
- in_notEmpty  in  1  upstream FIFO has a valid head entry
- in_deq_en  out  1  pop strobe to the upstream FIFO (combinational)
- flush  in  1  level; while high, emit any partial beat
- out_data  out  N_IN_BITS*N_PACK  packed beat; lane i occupies bits [i*N_IN_BITS +: N_IN_BITS]
- out_mask  out  N_PACK  bit i set means lane i holds data
- out_valid  out  1  beat is presented
- out_ready  in  1  sink accepts the beat this cycle
- busy  out  1  count>0 or out_valid

## Operation
- State: accumulator acc (N_PACK lanes), fill count cnt (0..N_PACK), output register (out_data/out_mask/out_valid), idle counter idle.
- slot_free = !out_valid || out_ready.
- Full transfer: cnt==N_PACK and slot_free. Load the output register from acc, set mask to all ones, and set cnt to 0.
- Partial transfer: 0<cnt<N_PACK and slot_free and (flush || (FLUSH_TIMEOUT!=0 && idle==FLUSH_TIMEOUT)). Load acc lanes 0..cnt-1. Zero all unused lanes. Set mask to (1<<cnt)-1. Set cnt to 0.
- xfer = full or partial transfer this cycle.
- Pop: in_deq_en = in_notEmpty && !reset && (cnt<N_PACK || xfer).
  - If xfer, the popped entry lands in lane 0 and cnt becomes 1.
  - Otherwise it lands in lane cnt and cnt increments.
- Lane order: the first entry popped goes to lane 0.
- in_deq_en is never asserted when in_notEmpty is low.
- Output register:
  - When xfer, out_valid becomes 1.
  - Otherwise, if out_ready, out_valid becomes 0.
  - out_data and out_mask hold steady while out_valid && !out_ready.
- idle:
  - Clears to 0 on any pop, any transfer, or when cnt==0.
  - Otherwise increments, saturating at FLUSH_TIMEOUT.
- flush with cnt==0 has no effect.
- flush with cnt==N_PACK behaves as a normal full transfer.
- Reset (asserted at any time, including mid-beat or with out_valid high):
  - out_valid, out_data, out_mask, cnt, acc and idle go to 0.
  - busy goes to 0; in_deq_en goes to 0.
  - Partially packed entries are discarded.
- Simulation-only checks: in_deq_en && !in_notEmpty is fatal. out_data/out_mask changing while out_valid && !out_ready is fatal.

## Timing
- Throughput: one entry per cycle, N_PACK entries per beat, with no bubbles when the sink is always ready.
- Latency: the last entry of a beat, popped at edge t, gives cnt==N_PACK after t. The transfer occurs at edge t+1, so out_valid is high during cycle t+1. Total: 2 cycles from pop to visible beat.
- Timeout path: after the last pop, idle reaches FLUSH_TIMEOUT after FLUSH_TIMEOUT edges. The partial beat is valid one edge later, provided slot_free.
- Flush path: flush high in cycle t with slot_free gives out_valid in cycle t+1.
- Backpressure: with out_valid && !out_ready and cnt==N_PACK, in_deq_en stays low. The upstream FIFO absorbs the stall.
- in_deq_en is combinational from in_notEmpty, out_valid, out_ready, flush, cnt and idle. It has no combinational path from in_first.

## Test plan
- Streaming: N_PACK=4, 8 entries 0x1..0x8 with FIFO always non-empty and out_ready=1.
  - Expect beats {0x4,0x3,0x2,0x1} then {0x8,0x7,0x6,0x5} (lane 3..0).
  - Expect mask 4'hF on both, and in_deq_en high for 8 consecutive cycles.
- Backpressure: out_ready=0 for 10 cycles with a continuous source.
  - Expect exactly 8 pops, one beat held stable, and in_deq_en low thereafter.
  - On release, both beats drain back-to-back.
- Timeout: FLUSH_TIMEOUT=16; push 0xA, 0xB, then stop.
  - Expect beat {0,0,0xB,0xA} with mask 4'h3 exactly 17 edges after the last pop.
- Flush racing a pop: cnt=3 with flush high and one entry 0xC available.
  - Expect the partial beat with mask 4'h7, 0xC in lane 0 of the next accumulator, and cnt=1.
- Reset mid-operation: assert reset asynchronously (off clock edge) with cnt=2 and out_valid=1.
  - Expect out_valid, busy, in_deq_en and out_mask at 0 immediately.
  - After release, the next beat contains only post-reset entries.
- Timeout disabled: FLUSH_TIMEOUT=0 with a partial fill held for 1000 cycles.
  - Expect no beat; a flush pulse then emits it.
